frame_loader: RTL and testbench

FRAME_LOADER -- requirements
Module: frame_loader

---
 rtl/frame_loader.sv | 133 +++++++++++++
 tb/tb_frame_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_loader.sv
// Double-buffered 16x32 frame loader: bytes fill a back buffer, and a
// completed frame is copied to the displayed front buffer at a safe point.
module frame_loader #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        swap_ok,
  output logic [31:0] matrix [15:0],
  output logic        busy,
  output logic        frame_done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_n;
  logic [5:0]  ptr;
  logic [5:0]  ptr_n;
  logic [7:0]  tmo;
  logic [7:0]  tmo_n;
  logic        wr;
  logic        swap;
  logic        abort;
  logic [31:0] back  [15:0];
  logic [31:0] front [15:0];

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    tmo_n   = tmo;
    wr      = 1'b0;
    swap    = 1'b0;
    abort   = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (frame_start) begin
          state_n = LOAD;
          ptr_n   = 6'd0;
          tmo_n   = 8'd0;
        end
      end
      (state == LOAD): begin
        // a restart wins over any byte offered in the same cycle
        if (frame_start) begin
          abort = 1'b1;
          ptr_n = 6'd0;
          tmo_n = 8'd0;
        end else if (byte_valid) begin
          wr    = 1'b1;
          ptr_n = ptr + 6'd1;
          tmo_n = 8'd0;
          if (ptr == 6'd63) begin
            state_n = PEND;
          end
        end else if (tmo == TMO_LAST) begin
          abort   = 1'b1;
          state_n = IDLE;
          ptr_n   = 6'd0;
          tmo_n   = 8'd0;
        end else begin
          tmo_n = tmo + 8'd1;
        end
      end
      (state == PEND): begin
        if (swap_ok) begin
          swap    = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= 6'd0;
      tmo        <= 8'd0;
      err        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      tmo        <= tmo_n;
      err        <= abort;
      frame_done <= swap;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 16; r++) begin
        back[r] <= 32'd0;
      end
    end else if (wr) begin
      back[ptr[5:2]][{ptr[1:0], 3'b000} +: 8] <= byte_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 16; r++) begin
        front[r] <= 32'd0;
      end
    end else if (swap) begin
      for (int r = 0; r < 16; r++) begin
        front[r] <= back[r];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 16; r++) begin
      matrix[r] = front[r];
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_frame_loader.sv
// Scoreboard bench for frame_loader: stimulus queues expected done/err
// events, a monitor pops and compares them as the outputs pulse.
module tb_frame_loader;

  typedef struct packed {
    logic              kind;
    logic [15:0][31:0] rows;
  } ev_t;

  localparam logic EV_DONE = 1'b0;
  localparam logic EV_ERR  = 1'b1;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        swap_ok;
  logic [31:0] matrix [15:0];
  logic        busy;
  logic        frame_done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  ev_t q[$];
  logic [15:0][31:0] cur;
  logic [15:0][31:0] exp_f;

  frame_loader #(.TIMEOUT(4)) dut (
    .clk(clk),
    .reset(reset),
    .frame_start(frame_start),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .swap_ok(swap_ok),
    .matrix(matrix),
    .busy(busy),
    .frame_done(frame_done),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  // monitor: every done/err pulse must match the oldest expected event
  always @(negedge clk) begin
    if (!reset && (frame_done || err)) begin
      ev_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event done=%0b err=%0b", frame_done, err);
      end else begin
        e = q.pop_front();
        if (frame_done == err || err != e.kind) begin
          errors++;
          $display("FAIL event_kind got done=%0b err=%0b want err=%0b",
                   frame_done, err, e.kind);
        end else begin
          for (int r = 0; r < 16; r++) begin
            if (matrix[r] !== e.rows[r]) begin
              errors++;
              $display("FAIL event_matrix row %0d got %h want %h",
                       r, matrix[r], e.rows[r]);
              break;
            end
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, want);
    end
  endtask

  task automatic chk_mat(input string nm, input logic [15:0][31:0] want);
    checks++;
    for (int r = 0; r < 16; r++) begin
      if (matrix[r] !== want[r]) begin
        errors++;
        $display("FAIL %s row %0d got %h want %h", nm, r, matrix[r], want[r]);
        break;
      end
    end
  endtask

  function automatic logic [15:0][31:0] fill(input logic [31:0] v);
    logic [15:0][31:0] f;
    for (int r = 0; r < 16; r++) f[r] = v;
    return f;
  endfunction

  task automatic push(input logic kind, input logic [15:0][31:0] rows);
    ev_t e;
    e.kind = kind;
    e.rows = rows;
    q.push_back(e);
  endtask

  task automatic start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] base, input bit incr, input int n);
    for (int i = 0; i < n; i++) begin
      byte_valid = 1'b1;
      byte_data  = incr ? base + 8'(i) : base;
      tick();
    end
    byte_valid = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    byte_valid  = 1'b0;
    byte_data   = 8'h00;
    swap_ok     = 1'b0;
    cur         = fill(32'h0);
    tick(2);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, frame_done}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk_mat("reset_matrix", cur);
    reset = 1'b0;
    tick(2);

    // full frame of 0x01 with swap_ok already high
    swap_ok  = 1'b1;
    busy_cnt = 0;
    start();
    tick();
    push(EV_DONE, fill(32'h01010101));
    send(8'h01, 1'b0, 64);
    tick(4);
    cur = fill(32'h01010101);
    chk("busy_cycles", 32'(busy_cnt), 32'd66);
    chk_mat("frame_01", cur);

    // incrementing frame held in PEND for 20 cycles
    swap_ok = 1'b0;
    start();
    send(8'h00, 1'b1, 64);
    for (int i = 0; i < 20; i++) begin
      chk("pend_busy", {31'd0, busy}, 32'd1);
      chk_mat("pend_hold", cur);
      tick();
    end
    for (int r = 0; r < 16; r++) begin
      exp_f[r] = {8'(4*r+3), 8'(4*r+2), 8'(4*r+1), 8'(4*r)};
    end
    push(EV_DONE, exp_f);
    swap_ok = 1'b1;
    tick(3);
    cur = exp_f;
    chk("inc_row0", matrix[0], 32'h03020100);
    chk("inc_row15", matrix[15], 32'h3F3E3D3C);

    // timeout after 10 bytes and 4 idle cycles
    start();
    send(8'h55, 1'b0, 10);
    push(EV_ERR, cur);
    tick(4);
    tick(3);
    chk("timeout_busy", {31'd0, busy}, 32'd0);
    chk_mat("timeout_matrix", cur);

    // restart after byte 30 with a byte in the restart cycle
    start();
    send(8'h20, 1'b1, 30);
    push(EV_ERR, cur);
    frame_start = 1'b1;
    byte_valid  = 1'b1;
    byte_data   = 8'h77;
    tick();
    frame_start = 1'b0;
    push(EV_DONE, fill(32'hFFFFFFFF));
    send(8'hFF, 1'b0, 64);
    tick(4);
    cur = fill(32'hFFFFFFFF);
    chk_mat("restart_matrix", cur);

    // traffic in IDLE without a start and during PEND is ignored
    swap_ok = 1'b0;
    send(8'h99, 1'b0, 5);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk_mat("idle_matrix", cur);
    start();
    send(8'h11, 1'b0, 64);
    frame_start = 1'b1;
    byte_valid  = 1'b1;
    byte_data   = 8'h99;
    tick(3);
    frame_start = 1'b0;
    byte_valid  = 1'b0;
    chk("pend_ign_busy", {31'd0, busy}, 32'd1);
    chk_mat("pend_ign_matrix", cur);
    push(EV_DONE, fill(32'h11111111));
    swap_ok = 1'b1;
    tick(3);
    cur = fill(32'h11111111);
    chk_mat("pend_ign_final", cur);

    // reset during PEND discards the loaded frame
    swap_ok = 1'b0;
    start();
    send(8'hAA, 1'b0, 64);
    tick();
    reset = 1'b1;
    #1;
    cur = fill(32'h0);
    chk_mat("rst_pend_matrix", cur);
    chk("rst_pend_busy", {31'd0, busy}, 32'd0);
    tick();
    reset   = 1'b0;
    swap_ok = 1'b1;
    tick(5);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk_mat("post_rst_matrix", cur);

    chk("events_left", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
